// File: rtl/cpu_mc_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, FSM states, ALU ops.
// Optional build macro used by the top: CPU_MC_PERF_CNT_EN.
package cpu_mc_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LW   = 4'h7;
  localparam logic [3:0] OP_SW   = 4'h8;
  localparam logic [3:0] OP_SLT  = 4'h9;
  localparam logic [3:0] OP_SHL  = 4'hA;
  localparam logic [3:0] OP_SHR  = 4'hB;
  localparam logic [3:0] OP_BNE  = 4'hC;
  localparam logic [3:0] OP_BEQ  = 4'hD;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_SHL,
    ALU_SHR
  } alu_op_e;

  // Which path an instruction takes out of EXEC.
  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_MEM,
    CLS_CTRL,
    CLS_HALT
  } op_class_e;

  function automatic alu_op_e alu_op_of(input logic [3:0] op);
    alu_op_e r;
    case (op)
      OP_SUB:  r = ALU_SUB;
      OP_AND:  r = ALU_AND;
      OP_OR:   r = ALU_OR;
      OP_XOR:  r = ALU_XOR;
      OP_SLT:  r = ALU_SLT;
      OP_SHL:  r = ALU_SHL;
      OP_SHR:  r = ALU_SHR;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

  function automatic op_class_e class_of(input logic [3:0] op);
    op_class_e r;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SLT, OP_SHL, OP_SHR, OP_ADDI:         r = CLS_ALU;
      OP_LW, OP_SW:                            r = CLS_MEM;
      OP_HALT:                                 r = CLS_HALT;
      OP_JMP, OP_BNE, OP_BEQ, OP_NOP:          r = CLS_CTRL;
      default:                                 r = CLS_CTRL;
    endcase
    return r;
  endfunction

  // SW and the branches read rd as their second source operand.
  function automatic logic reads_rd(input logic [3:0] op);
    return (op == OP_SW) || (op == OP_BNE) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/cpu_mc_regfile.sv
// NREG x DATA_W register file: two combinational read ports, one write port.
// r0 has no storage and always reads zero; indices >= NREG read zero and ignore writes.
module cpu_mc_regfile
  import cpu_mc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        raddr_a_i,
  input  logic [3:0]        raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic              we_i,
  input  logic [3:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [DATA_W-1:0] rf_q [1:NREG-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) rf_q[i] <= '0;
    end else if (we_i) begin
      for (int i = 1; i < NREG; i++) begin
        if (waddr_i == 4'(i)) rf_q[i] <= wdata_i;
      end
    end
  end

  always_comb begin
    rdata_a_o = '0;
    rdata_b_o = '0;
    for (int i = 1; i < NREG; i++) begin
      if (raddr_a_i == 4'(i)) rdata_a_o = rf_q[i];
      if (raddr_b_i == 4'(i)) rdata_b_o = rf_q[i];
    end
  end

endmodule

// File: rtl/cpu_mc_core.sv
// Multi-cycle 16-bit-ISA core: FETCH/DECODE/EXEC/MEM/WB with req/ready memories.
// CPU_MC_PERF_CNT_EN adds 32-bit cycle and retired-instruction counters.
//
// state  | meaning
// FETCH  | imem_req high at pc until imem_ready, latch IR
// DECODE | latch operands A (rs1) and B (rs2, or rd for SW/branches)
// EXEC   | ALU result, memory address or branch target
// MEM    | dmem_req held stable until dmem_ready
// WB     | write rd, pc += 1
// HALT   | terminal, no requests until reset
module cpu_mc_core
  import cpu_mc_pkg::*;
#(
  parameter int              DATA_W   = 16,
  parameter int              NREG     = 16,
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              halted,
  output logic              retire
`ifdef CPU_MC_PERF_CNT_EN
  ,
  output logic [31:0]       cyc_cnt,
  output logic [31:0]       inst_cnt
`endif
);

  localparam int SHW = $clog2(DATA_W);

  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [15:0]       ir_q;
  logic [DATA_W-1:0] a_q, b_q, res_q, maddr_q, mwdata_q;

  logic [3:0]        op, rd, rs1, rs2;
  op_class_e         op_cls;
  logic [DATA_W-1:0] imm_d, opb_d, alu_d, rf_a, rf_b;
  logic [PC_W-1:0]   imm_pc, pc_inc_d, pc_ctrl_d;

  assign op     = ir_q[15:12];
  assign rd     = ir_q[11:8];
  assign rs1    = ir_q[7:4];
  assign rs2    = ir_q[3:0];
  assign op_cls = class_of(op);
  assign imm_d  = {{(DATA_W-4){ir_q[3]}}, ir_q[3:0]};
  assign imm_pc = {{(PC_W-4){ir_q[3]}}, ir_q[3:0]};

  cpu_mc_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .raddr_a_i (rs1),
    .raddr_b_i (reads_rd(op) ? rd : rs2),
    .rdata_a_o (rf_a),
    .rdata_b_o (rf_b),
    .we_i      (state_q == ST_WB),
    .waddr_i   (rd),
    .wdata_i   (res_q)
  );

  always_comb begin
    opb_d = b_q;
    if (op == OP_ADDI || op == OP_LW || op == OP_SW) opb_d = imm_d;
    alu_d = '0;
    case (alu_op_of(op))
      ALU_ADD: alu_d = a_q + opb_d;
      ALU_SUB: alu_d = a_q - opb_d;
      ALU_AND: alu_d = a_q & opb_d;
      ALU_OR:  alu_d = a_q | opb_d;
      ALU_XOR: alu_d = a_q ^ opb_d;
      ALU_SLT: alu_d = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(opb_d))};
      ALU_SHL: alu_d = a_q << opb_d[SHW-1:0];
      ALU_SHR: alu_d = a_q >> opb_d[SHW-1:0];
      default: alu_d = '0;
    endcase
  end

  // Branches compare rd (latched in B) against rs1 (latched in A).
  assign pc_inc_d = pc_q + PC_W'(1);
  always_comb begin
    pc_ctrl_d = pc_inc_d;
    case (op)
      OP_JMP: pc_ctrl_d = PC_W'(ir_q[11:0]);
      OP_BNE: if (a_q != b_q) pc_ctrl_d = pc_inc_d + imm_pc;
      OP_BEQ: if (a_q == b_q) pc_ctrl_d = pc_inc_d + imm_pc;
      default: pc_ctrl_d = pc_inc_d;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_ready) begin
            ir_q    <= imem_rdata;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          a_q     <= rf_a;
          b_q     <= rf_b;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          case (op_cls)
            CLS_ALU: begin
              res_q   <= alu_d;
              state_q <= ST_WB;
            end
            CLS_MEM: begin
              maddr_q  <= alu_d;
              mwdata_q <= b_q;
              state_q  <= ST_MEM;
            end
            CLS_HALT: state_q <= ST_HALT;
            default: begin
              pc_q    <= pc_ctrl_d;
              state_q <= ST_FETCH;
            end
          endcase
        end
        ST_MEM: begin
          if (dmem_ready) begin
            if (op == OP_SW) begin
              pc_q    <= pc_inc_d;
              state_q <= ST_FETCH;
            end else begin
              res_q   <= dmem_rdata;
              state_q <= ST_WB;
            end
          end
        end
        ST_WB: begin
          pc_q    <= pc_inc_d;
          state_q <= ST_FETCH;
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  // Requests are gated by rst so they are low throughout reset and drop the instant it rises.
  assign imem_req   = (state_q == ST_FETCH) & ~rst;
  assign imem_addr  = imem_req ? pc_q : '0;
  assign dmem_req   = (state_q == ST_MEM) & ~rst;
  assign dmem_we    = dmem_req & (op == OP_SW);
  assign dmem_addr  = dmem_req ? maddr_q : '0;
  assign dmem_wdata = dmem_req ? mwdata_q : '0;
  assign halted     = (state_q == ST_HALT);

  always_comb begin
    retire = 1'b0;
    case (state_q)
      ST_WB:   retire = 1'b1;
      ST_MEM:  retire = dmem_ready & (op == OP_SW);
      ST_EXEC: retire = (op_cls == CLS_CTRL) || (op_cls == CLS_HALT);
      default: retire = 1'b0;
    endcase
  end

`ifdef CPU_MC_PERF_CNT_EN
  logic [31:0] cyc_cnt_q, inst_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt_q  <= '0;
      inst_cnt_q <= '0;
    end else begin
      if (state_q != ST_HALT) cyc_cnt_q <= cyc_cnt_q + 32'd1;
      if (retire) inst_cnt_q <= inst_cnt_q + 32'd1;
    end
  end

  assign cyc_cnt  = cyc_cnt_q;
  assign inst_cnt = inst_cnt_q;
`else
  // Counters and their ports are not built.
`endif

endmodule

// File: doc/cpu_mc_core.md
# cpu_mc_core

Parametrised multi-cycle successor to the single-cycle 16-bit core. It executes the same 16-bit instruction format through a FETCH/DECODE/EXEC/MEM/WB state machine. Instruction and data memories sit behind req/ready handshakes, so wait states stall the core. The datapath width and register count are generic, and the block becomes the top-level CPU instance feeding the external imem/dmem wrappers.

## Interface
- DATA_W, 16: datapath and register width, ≥16
- NREG, 16: architectural registers, 2..16; r0 is hardwired to zero
- PC_W, 16: program counter and imem address width
- RESET_PC, 0: PC value after reset
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous and active-high
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (word)
- imem_ready  in  1  fetch complete; imem_rdata valid
- imem_rdata  in  16  instruction word
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  DATA_W  data address (word)
- dmem_wdata  out  DATA_W  store data
- dmem_ready  in  1  access complete; dmem_rdata valid for loads
- dmem_rdata  in  DATA_W  load data
- halted  out  1  core has executed HALT
- retire  out  1  one-cycle pulse per completed instruction

## Operation
- Instruction fields:
  - op = [15:12], rd = [11:8], rs1 = [7:4], rs2/imm4 = [3:0]
  - imm = sign-extended imm4 to DATA_W
  - Register indices ≥ NREG read as 0; writes to them are dropped.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 5 XOR, 9 SLT (signed)
  - A SHL, B SHR (logical, amount = rs2[$clog2(DATA_W)-1:0])
  - 6 ADDI: rd = rs1 + imm
  - 7 LW: rd = M[rs1 + imm]
  - 8 SW: M[rs1 + imm] = rd
  - 4 JMP: pc = zero-extended [11:0]
  - C BNE and D BEQ: compare rd with rs1; if taken, pc = pc + 1 + imm
  - F HALT
  - E and any unused opcode: NOP
- States:
  - FETCH: hold imem_req=1 and imem_addr=pc until imem_ready; latch IR on ready; go to DECODE.
  - DECODE: latch operands A and B from the register file; go to EXEC.
  - EXEC: compute the ALU result or branch condition.
    - ALU ops go to WB.
    - LW/SW go to MEM.
    - Branch/JMP/NOP update pc and go to FETCH.
    - HALT goes to HALT.
  - MEM: hold dmem_req, dmem_we, dmem_addr and dmem_wdata stable until dmem_ready.
    - LW latches the data and goes to WB.
    - SW does pc+1 and goes to FETCH.
  - WB: write rd (suppressed for r0); pc += 1; go to FETCH.
  - HALT: terminal; halted=1; no requests issued until reset.
- retire pulses in the cycle of the pc update: WB, SW-MEM-done, EXEC for branch/JMP/NOP, and on entering HALT.
- Arithmetic wraps modulo 2^DATA_W; pc arithmetic wraps modulo 2^PC_W.
- ready asserted while the matching req is low is ignored.

## Timing
- Reset: state=FETCH, pc=RESET_PC, all registers 0, all outputs 0. First imem_req is asserted in the first cycle after rst deasserts.
- Zero-wait memory (ready in the same cycle as req) gives these cycles per instruction:
  - ALU/ADDI: 4
  - LW: 5
  - SW: 4
  - branch/JMP/NOP: 3
- Each memory wait cycle adds exactly one cycle.
- rst asserted mid-FETCH or mid-MEM drops req immediately; a pending store is abandoned.
- Register write and read of the same register never collide, because WB and DECODE are in distinct states.

## Configuration
- CPU_MC_PERF_CNT_EN defined:
  - adds outputs cyc_cnt and inst_cnt, 32 bits each, reset to 0
  - cyc_cnt increments every non-HALT cycle
  - inst_cnt increments on retire
  - both wrap at 2^32
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package cpu_mc_pkg holds:
  - opcode constants, replacing the ad-hoc values in def_opcode.v
  - state enum encoding
  - ALU operation codes
- One sub-module, cpu_mc_regfile: NREG×DATA_W, two combinational read ports, one synchronous write port, r0 forced to zero, asynchronous reset to 0.

## Test plan
- ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2 -> r3=2; retire after 4 cycles per instruction with zero-wait memory.
- SW r1,[r0+2] then LW r4,[r0+2] with dmem_ready delayed 3 cycles -> dmem_req/addr/wdata stable for the whole wait; r4=5; LW takes 8 cycles.
- BEQ r1,r1,-1 at pc=10 -> next fetch at 10 (loop). BNE r1,r1 -> pc=11. JMP 0xABC -> imem_addr=0x0ABC.
- ADDI r0,r0,7 -> r0 reads back 0. SHL with r2=0x13 and DATA_W=16 -> shift by 3.
- HALT -> halted=1, no further imem_req. rst pulsed mid-MEM -> req drops asynchronously; restart at RESET_PC.
- CPU_MC_PERF_CNT_EN defined, 3-instruction program + HALT -> inst_cnt=4; cyc_cnt equals the sum of the per-instruction cycle counts.
